// File: rtl/ntt_bf_pipe.sv
// Pipelined modular NTT butterfly: Cooley-Tukey (mode 0) or Gentleman-Sande (mode 1).
// A result appears three edges after its operands are accepted; one global stall holds every stage.
module ntt_bf_pipe #(
    parameter int unsigned W = 23,
    parameter int unsigned Q = 8380417
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic [W-1:0] TF,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic         busy
);

    localparam logic [W:0]     Q1 = (W+1)'(Q);
    localparam logic [2*W-1:0] Q2 = (2*W)'(Q);

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q1)
            s = s - Q1;
        return W'(s);
    endfunction

    // A negative difference is corrected by a single addition of Q.
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a >= b)
            return a - b;
        return W'({1'b0, a} + Q1 - {1'b0, b});
    endfunction

    logic           advance;
    logic [W-1:0]   pre_x;
    logic [W-1:0]   pre_m;

    logic           s1_v, s1_mode;
    logic [W-1:0]   s1_x, s1_m, s1_tf;
    logic           s2_v, s2_mode;
    logic [W-1:0]   s2_x;
    logic [2*W-1:0] s2_p;
    logic           s3_v, s3_mode;
    logic [W-1:0]   s3_x, s3_t;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign busy     = s1_v || s2_v || s3_v || out_valid;

    // Gentleman-Sande forms the sum and difference before the multiply.
    always_comb begin
        pre_x = X;
        pre_m = Y;
        if (mode) begin
            pre_x = add_mod(X, Y);
            pre_m = sub_mod(X, Y);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_mode <= 1'b0;
            s1_x    <= '0;
            s1_m    <= '0;
            s1_tf   <= '0;
            s2_v    <= 1'b0;
            s2_mode <= 1'b0;
            s2_x    <= '0;
            s2_p    <= '0;
            s3_v    <= 1'b0;
            s3_mode <= 1'b0;
            s3_x    <= '0;
            s3_t    <= '0;
        end else if (advance) begin
            s1_v    <= in_valid;
            s1_mode <= mode;
            s1_x    <= pre_x;
            s1_m    <= pre_m;
            s1_tf   <= TF;

            s2_v    <= s1_v;
            s2_mode <= s1_mode;
            s2_x    <= s1_x;
            s2_p    <= {{W{1'b0}}, s1_m} * {{W{1'b0}}, s1_tf};

            // The whole 2W-bit product is reduced, so the remainder is exact.
            s3_v    <= s2_v;
            s3_mode <= s2_mode;
            s3_x    <= s2_x;
            s3_t    <= W'(s2_p % Q2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            A         <= '0;
            B         <= '0;
        end else if (advance) begin
            out_valid <= s3_v;
            A         <= s3_mode ? s3_x : add_mod(s3_x, s3_t);
            B         <= s3_mode ? s3_t : sub_mod(s3_x, s3_t);
        end
    end

endmodule

// File: doc/ntt_bf_pipe.md
NTT_BF_PIPE -- requirements
Module: ntt_bf_pipe

Interface
REQ-001 SHALL have parameter W, default 23, coefficient width in bits.
REQ-002 SHALL have parameter Q, default 8380417, modulus; Q < 2^W, Q odd.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input operand set valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-007 SHALL have port mode  input  1  0 = Cooley-Tukey (forward NTT), 1 = Gentleman-Sande (inverse NTT); sampled with operands.
REQ-008 SHALL have ports X, Y, TF  input  W each  operands and twiddle, each in [0, Q-1].
REQ-009 SHALL have port out_valid  output  1  A/B hold a valid result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have ports A, B  output  W each  butterfly results, each in [0, Q-1].
REQ-012 SHALL have port busy  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-013 Mode 0: A = (X + Y*TF) mod Q; B = (X - Y*TF) mod Q.
REQ-014 Mode 1: A = (X + Y) mod Q; B = ((X - Y) * TF) mod Q.
REQ-015 All results fully reduced to [0, Q-1]; the full 2W-bit product is reduced exactly, with no truncation.
REQ-016 Negative intermediate differences are corrected by adding Q exactly once.
REQ-017 Operands outside [0, Q-1] produce unspecified A/B values; valid/handshake timing is unaffected.
REQ-018 Pipeline is 3 stages with registered outputs: an operand set accepted at edge N, with no stall, yields out_valid=1 and its result after edge N+3.
REQ-019 Transfer in occurs on an edge with in_valid && in_ready; transfer out occurs on an edge with out_valid && out_ready.
REQ-020 in_ready = !out_valid || out_ready, a single global stall; in_ready depends combinationally only on out_valid and out_ready, never on in_valid.
REQ-021 When out_valid && !out_ready, all stages hold, and A, B and out_valid stay stable until the transfer.
REQ-022 Each stage carries its own valid bit and mode bit; mixed-mode sequences back-to-back are computed per entry, with no flush.
REQ-023 Sustained throughput is 1 result/cycle while in_valid and out_ready are both held high.
REQ-024 Bubbles (in_valid=0 while in_ready=1) propagate as invalid stages; they never produce out_valid.
REQ-025 Results exit in acceptance order; no entry is dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 busy = OR of all stage valid bits.

Reset
REQ-027 rst asserted clears all stage valid bits immediately: out_valid=0, busy=0, A=0, B=0.
REQ-028 rst asserted mid-operation discards all in-flight entries; no result from before the reset ever appears.
REQ-029 in_ready=1 during and after reset, because out_valid=0.
REQ-030 After rst deasserts, the first accepted operand set appears after exactly 3 edges.

Verification
REQ-031 Mode 0, X=1, Y=2, TF=3, out_ready=1 -> 3 cycles later A=7, B=8380412.
REQ-032 Mode 1, X=5, Y=8, TF=2 -> A=13, B=8380411; mode 0, X=8380416, Y=1, TF=1 -> A=0, B=8380415.
REQ-033 Mode 0, X=0, Y=8380416, TF=8380416 -> A=1, B=8380416 (maximum product reduced exactly).
REQ-034 Stream of 20 random mixed-mode sets with random out_ready stalls -> results match the reference model in order, out_valid never drops without a transfer, and A/B stay stable while stalled.
REQ-035 rst pulsed with 3 entries in flight -> out_valid=0 and busy=0 immediately; no stale result afterwards; the next input's result appears 3 cycles after acceptance.
REQ-036 in_valid=1 and out_ready=1 held for 100 cycles -> 100 results in 102 cycles (fill latency plus one per cycle).
